// File: rtl/mio_pkg.sv
// mio_pkg -- shared definitions for the memory-interface bus controller.
//   mio_state_e   : controller state encoding (IDLE=0, BUS=1, DONE=2)
//   ALIGN_MASK    : byte-offset bits that must be zero for a word access
//   is_misaligned : true when the low address bits violate ALIGN_MASK
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } mio_state_e;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] addr_lo);
      return (addr_lo & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mio_timeout_cnt.sv
// mio_timeout_cnt -- bus wait-cycle counter, only built with MIO_TIMEOUT_EN.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clr_i    : hold counter at zero (asserted whenever the bus is idle)
//   inc_i    : count one un-acknowledged bus cycle
//   expire_o : this un-acknowledged cycle brings the count to TIMEOUT
module mio_timeout_cnt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the cycle whose increment would reach TIMEOUT, so the controller
   // leaves BUS after exactly TIMEOUT un-acknowledged cycles.
   assign expire_o = inc_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl -- single-outstanding memory bus controller for the multicycle
// control FSM. Captures a read/write request, runs one bus cycle, returns a
// one-cycle MIO_ready pulse (with err on misalignment or timeout).
//   clk, reset              : clock (rising edge), async active-low reset
//   MemRead, MemWrite       : request strobes from the control FSM (write wins)
//   addr, wdata             : byte address and store data, latched at capture
//   mem_rdata, mem_ack      : bus read data and completion strobe
//   mem_req, mem_we         : bus cycle active / bus cycle is a write
//   mem_addr, mem_wdata     : latched address and store data
//   MIO_ready, err          : completion pulse and coincident error pulse
//   mdr                     : memory data register, loaded by successful reads
// Optional feature: define MIO_TIMEOUT_EN to abort a bus cycle after TIMEOUT
// un-acknowledged cycles.
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              MIO_ready,
   output logic [DATA_W-1:0] mdr,
   output logic              err
);

   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("mio_bus_ctrl: TIMEOUT must be at least 1");
   end

   mio_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;
   logic              tmo_hit;

`ifdef MIO_TIMEOUT_EN
   mio_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i    (clk),
      .rst_ni   (reset),
      .clr_i    (state_q != BUS),
      .inc_i    ((state_q == BUS) && !mem_ack),
      .expire_o (tmo_hit)
   );
`else
   // No counter: BUS waits for mem_ack indefinitely.
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mdr_d   = mdr_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (MemRead || MemWrite) begin
               we_d    = MemWrite;
               addr_d  = addr;
               wdata_d = wdata;
               // A misaligned request never reaches the bus.
               if (is_misaligned(addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            // Ack takes priority over a coincident timeout.
            if (mem_ack) begin
               if (!we_q) begin
                  mdr_d = mem_rdata;
               end
               err_d   = 1'b0;
               state_d = DONE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
      end
   end

   assign mem_req   = (state_q == BUS);
   assign mem_we    = (state_q == BUS) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign MIO_ready = (state_q == DONE);
   assign err       = (state_q == DONE) && err_q;
   assign mdr       = mdr_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl -- self-checking bench for mio_bus_ctrl. A transaction-level
// model predicts every cycle's outputs; a negedge process compares them.
// Define MIO_TIMEOUT_EN to also exercise the timeout path (TIMEOUT=4).
module tb_mio_bus_ctrl;

   localparam int unsigned TMO = 4;
`ifdef MIO_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] addr, wdata, mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, MIO_ready, err;
   logic [31:0] mem_addr, mem_wdata, mdr;

   mio_bus_ctrl #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .addr      (addr),
      .wdata     (wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .MIO_ready (MIO_ready),
      .mdr       (mdr),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endfunction

   // Model state (what the controller has latched)
   logic        m_we;
   logic [31:0] m_addr, m_wdata, m_mdr;
   // Expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic        e_req, e_ready, e_err, e_we;
   logic [31:0] e_addr, e_wdata, e_mdr;
   // Free-running event counters for directed checks
   int n_req = 0, n_rdy = 0, n_err = 0;

   function automatic void set_exp(input bit rq, input bit rdy, input bit er);
      e_req   = rq;
      e_ready = rdy;
      e_err   = er;
      e_we    = m_we;
      e_addr  = m_addr;
      e_wdata = m_wdata;
      e_mdr   = m_mdr;
   endfunction

   always @(negedge clk) begin
      if (mem_req === 1'b1)   n_req++;
      if (MIO_ready === 1'b1) n_rdy++;
      if (err === 1'b1)       n_err++;
      if (chk_en) begin
         chk("mem_req", mem_req, e_req);
         chk("MIO_ready", MIO_ready, e_ready);
         chk("err", err, e_err);
         chk("mdr", mdr, e_mdr);
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
         if (e_req) chk("mem_we", mem_we, e_we);
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req_inputs();
      {MemRead, MemWrite} = 2'($urandom);
      addr      = $urandom;
      wdata     = $urandom;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
   endtask

   task automatic do_idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         addr      = $urandom;
         wdata     = $urandom;
         mem_ack   = 1'($urandom);
         mem_rdata = $urandom;
         adv();
         set_exp(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Entered at posedge+1 of a cycle in which the controller is idle.
   // nwait = un-acknowledged bus cycles before the ack.
   task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int unsigned nwait,
                         input logic [31:0] rdata, input bit hold);
      bit          tmo;
      bit          er;
      int unsigned nbus;
      MemRead   = rd;
      MemWrite  = wr;
      addr      = a;
      wdata     = wd;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      m_we      = wr;
      m_addr    = a;
      m_wdata   = wd;
      adv();
      if (a[1:0] != 2'b00) begin
         er = 1'b1;
      end else begin
         tmo  = TMO_EN && (nwait >= TMO);
         nbus = tmo ? TMO : nwait + 1;
         for (int unsigned k = 0; k < nbus; k++) begin
            set_exp(1'b1, 1'b0, 1'b0);
            if (hold) begin
               MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
            end else begin
               {MemRead, MemWrite} = 2'($urandom);
               addr  = $urandom;
               wdata = $urandom;
            end
            mem_ack   = !tmo && (k == nwait);
            mem_rdata = (k == nwait) ? rdata : $urandom;
            adv();
         end
         if (!tmo && !wr) m_mdr = rdata;
         er = tmo;
      end
      set_exp(1'b0, 1'b1, er);
      if (hold) begin
         MemRead = rd; MemWrite = wr; addr = a; wdata = wd;
         mem_ack = 1'($urandom); mem_rdata = $urandom;
      end else begin
         rand_req_inputs();
      end
      adv();
      set_exp(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s_req, s_rdy, s_err;
      bit rd, wr;
      int unsigned nw;
      logic [31:0] a;
      reset = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst mem_we", mem_we, 1'b0);
      chk("rst MIO_ready", MIO_ready, 1'b0);
      chk("rst err", err, 1'b0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst mdr", mdr, 32'h0);
      adv();
      reset = 1'b1;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_mdr = '0;
      set_exp(1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;

      // Read, ack in first bus cycle
      s_req = n_req; s_rdy = n_rdy; s_err = n_err;
      do_txn(1'b1, 1'b0, 32'h10, 32'h5555_AAAA, 0, 32'h1234_5678, 1'b0);
      chk("read mdr", mdr, 32'h1234_5678);
      chk("read req cycles", n_req - s_req, 1);
      chk("read ready pulses", n_rdy - s_rdy, 1);
      chk("read err pulses", n_err - s_err, 0);

      // Write with 3 wait cycles
      do_idle(1);
      s_req = n_req; s_rdy = n_rdy; s_err = n_err;
      do_txn(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b0);
      chk("write req cycles", n_req - s_req, 4);
      chk("write ready pulses", n_rdy - s_rdy, 1);
      chk("write mdr kept", mdr, 32'h1234_5678);
      chk("write mem_wdata", mem_wdata, 32'hCAFE_F00D);

      // Both strobes: write wins, mdr untouched
      do_txn(1'b1, 1'b1, 32'h24, 32'h0F0F_0F0F, 1, 32'h7777_7777, 1'b0);
      chk("rw mdr kept", mdr, 32'h1234_5678);

      // Misaligned
      s_req = n_req; s_rdy = n_rdy; s_err = n_err;
      do_txn(1'b1, 1'b0, 32'h13, 32'h0, 2, 32'h9999_9999, 1'b0);
      chk("misalign req cycles", n_req - s_req, 0);
      chk("misalign ready pulses", n_rdy - s_rdy, 1);
      chk("misalign err pulses", n_err - s_err, 1);

      // Back-to-back with request held through DONE
      s_rdy = n_rdy;
      do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hA5A5_0001, 1'b1);
      do_txn(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'hA5A5_0002, 1'b1);
      do_idle(2);
      chk("b2b ready pulses", n_rdy - s_rdy, 2);
      chk("b2b mdr", mdr, 32'hA5A5_0002);

      // Long wait: timeout when enabled, otherwise the bus keeps waiting
      s_req = n_req; s_err = n_err;
      do_txn(1'b1, 1'b0, 32'h80, 32'h0, 10, 32'h0BAD_0001, 1'b0);
      chk("long req cycles", n_req - s_req, TMO_EN ? TMO : 11);
      chk("long err pulses", n_err - s_err, TMO_EN ? 1 : 0);
      chk("long mdr", mdr, TMO_EN ? 32'hA5A5_0002 : 32'h0BAD_0001);
      // Ack on the last permitted cycle beats the timeout
      s_err = n_err;
      do_txn(1'b1, 1'b0, 32'h84, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0);
      chk("edge ack err pulses", n_err - s_err, 0);
      chk("edge ack mdr", mdr, 32'h0BAD_F00D);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         {wr, rd} = 2'($urandom_range(1, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         nw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 9) : $urandom_range(0, 3);
         do_txn(rd, wr, a, $urandom, nw, $urandom, 1'($urandom));
         do_idle($urandom_range(0, 2));
      end

      // Reset in the middle of a bus wait
      s_rdy = n_rdy;
      MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h100; wdata = 32'h1111_2222;
      mem_ack = 1'b0;
      m_we = 1'b0; m_addr = 32'h100; m_wdata = 32'h1111_2222;
      adv();
      set_exp(1'b1, 1'b0, 1'b0);
      MemRead = 1'b0;
      adv();
      chk_en = 1'b0;
      chk("pre-reset mem_req", mem_req, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("async rst mem_req", mem_req, 1'b0);
      chk("async rst mem_we", mem_we, 1'b0);
      chk("async rst MIO_ready", MIO_ready, 1'b0);
      chk("async rst err", err, 1'b0);
      chk("async rst mem_addr", mem_addr, 32'h0);
      chk("async rst mem_wdata", mem_wdata, 32'h0);
      chk("async rst mdr", mdr, 32'h0);
      mem_ack = 1'b1;
      adv();
      adv();
      reset = 1'b1;
      mem_ack = 1'b0;
      chk("rst no ready", n_rdy - s_rdy, 0);
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_mdr = '0;
      set_exp(1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      do_txn(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h600D_CAFE, 1'b0);
      do_idle(2);
      chk("post-reset mdr", mdr, 32'h600D_CAFE);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
